dct_row_pass: RTL



---
 rtl/dct_row_pass_pkg.sv | 36 +++
 rtl/dct_row_pass_if.sv | 11 +
 rtl/dct_coef_rom.sv | 15 +
 rtl/dct_row_pass.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dct_row_pass_pkg.sv
// Shared types and constants for the 8-point DCT row/column pass.
// Cosine table is round(4096 * c(u)/2 * cos((2i+1)u*pi/16)).
package dct_row_pass_pkg;

  localparam int DCT_W     = 16;
  localparam int COEF_FRAC = 12;
  localparam int COEF_W    = COEF_FRAC + 2;
  localparam int PROD_W    = DCT_W + 1 + COEF_W;
  localparam int ACC_W     = PROD_W + 2;

  typedef struct packed {
    logic [DCT_W-1:0] data;
    logic             valid;
    logic             sop;
    logic             eop;
  } dctPort_t;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [DCT_W:0]    bfly_t;

  localparam logic [2:0] PAIR_ORDER [8] = '{
    3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd5, 3'd3, 3'd4
  };

  localparam coef_t COEF_TAB [8][4] = '{
    '{ 14'sd1448,  14'sd1448,  14'sd1448,  14'sd1448},
    '{ 14'sd2009,  14'sd1703,  14'sd1138,  14'sd400 },
    '{ 14'sd1892,  14'sd784,  -14'sd784,  -14'sd1892},
    '{ 14'sd1703, -14'sd400,  -14'sd2009, -14'sd1138},
    '{ 14'sd1448, -14'sd1448, -14'sd1448,  14'sd1448},
    '{ 14'sd1138, -14'sd2009,  14'sd400,   14'sd1703},
    '{ 14'sd784,  -14'sd1892,  14'sd1892, -14'sd784 },
    '{ 14'sd400,  -14'sd1138,  14'sd1703, -14'sd2009}
  };

endpackage

// File: rtl/dct_row_pass_if.sv
// Sample/coefficient stream bundle for the DCT passes.
// Master drives the port struct, slave observes it.
interface dct_row_pass_if;
  import dct_row_pass_pkg::*;

  dctPort_t p;

  modport master (output p);
  modport slave  (input  p);

endinterface

// File: rtl/dct_coef_rom.sv
// Cosine constant lookup: returns the four C[u][i] for one output
// index u, feeding the four parallel multipliers.
module dct_coef_rom
  import dct_row_pass_pkg::*;
(
  input  logic [2:0] i_u,
  output coef_t      o_coef [4]
);

  always_comb begin
    for (int i = 0; i < 4; i++)
      o_coef[i] = COEF_TAB[i_u][i];
  end

endmodule

// File: rtl/dct_row_pass.sv
// 8-point forward DCT over rows arriving in pair order 0,7,1,6,2,5,3,4.
// Define DCT_LEVEL_SHIFT_EN for the pixel row pass (data[7:0] - 128).
module dct_row_pass
  import dct_row_pass_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  dct_row_pass_if.slave  in,
  dct_row_pass_if.master out,
  output logic           err
);

  localparam logic signed [ACC_W-1:0] L_RND =
    ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] L_MAX =
    ACC_W'(2 ** (DCT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] L_MIN =
    ACC_W'(-(2 ** (DCT_W - 1)));

  logic [2:0]              r_cnt;
  logic signed [DCT_W-1:0] r_first;
  logic                    r_row_sop;
  logic                    r_err;
  bfly_t                   r_s [2][4];
  bfly_t                   r_d [2][4];

  logic       r_fbank;
  logic       r_cbank;
  logic       r_busy;
  logic [2:0] r_u;
  logic       r_c_sop;
  logic       r_c_eop;

  logic signed [PROD_W-1:0] r_prod [4];
  logic                     r_pvalid;
  logic                     r_psop;
  logic                     r_peop;
  dctPort_t                 r_out;

  logic signed [DCT_W-1:0]  w_x;
  logic                     w_acc;
  logic [2:0]               w_idx;
  logic [2:0]               w_cnt_a;
  logic [2:0]               w_cnt_n;
  logic                     w_done;
  logic                     w_sop_drop;
  logic                     w_eop_drop;
  logic                     w_drop;
  logic                     w_tag_new;
  logic                     w_tag_old;
  logic [1:0]               w_slot;
  coef_t                    w_coef [4];
  bfly_t                    w_op   [4];
  logic signed [PROD_W-1:0] w_mul  [4];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shr;
  logic [DCT_W-1:0]         w_sat;

`ifdef DCT_LEVEL_SHIFT_EN
  assign w_x = DCT_W'($signed({1'b0, in.p.data[7:0]}) - 9'sd128);
`else
  assign w_x = $signed(in.p.data);
`endif

  // A sop always restarts the row, so it forces this sample to index 0.
  assign w_acc      = in.p.valid;
  assign w_idx      = in.p.sop ? 3'd0 : r_cnt;
  assign w_cnt_a    = w_acc ? w_idx + 3'd1 : r_cnt;
  assign w_done     = w_acc && (w_idx == 3'd7);
  assign w_sop_drop = w_acc && in.p.sop && (r_cnt != 3'd0);
  assign w_eop_drop = in.p.eop && (w_cnt_a != 3'd0);
  assign w_drop     = w_sop_drop || w_eop_drop;
  assign w_cnt_n    = w_eop_drop ? 3'd0 : w_cnt_a;
  assign w_tag_new  = in.p.eop && w_done;
  assign w_tag_old  = in.p.eop && !w_done;
  assign w_slot     = 2'(PAIR_ORDER[{w_idx[2:1], 1'b0}]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_first   <= '0;
      r_row_sop <= 1'b0;
      r_err     <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 4; i++) begin
          r_s[b][i] <= '0;
          r_d[b][i] <= '0;
        end
    end else begin
      r_cnt <= w_cnt_n;
      r_err <= w_drop;
      if (w_acc && !w_idx[0])
        r_first <= w_x;
      if (w_acc && (w_idx == 3'd0))
        r_row_sop <= in.p.sop;
      if (w_acc && w_idx[0] && !w_eop_drop) begin
        r_s[r_fbank][w_slot] <= bfly_t'(r_first) + bfly_t'(w_x);
        r_d[r_fbank][w_slot] <= bfly_t'(r_first) - bfly_t'(w_x);
      end
    end
  end

  // A new row can only complete once the previous compute is at u=7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fbank <= 1'b0;
      r_cbank <= 1'b0;
      r_busy  <= 1'b0;
      r_u     <= '0;
      r_c_sop <= 1'b0;
      r_c_eop <= 1'b0;
    end else if (w_done) begin
      r_fbank <= ~r_fbank;
      r_cbank <= r_fbank;
      r_busy  <= 1'b1;
      r_u     <= '0;
      r_c_sop <= r_row_sop;
      r_c_eop <= w_tag_new;
    end else if (r_busy) begin
      r_u    <= r_u + 3'd1;
      r_busy <= (r_u != 3'd7);
      if (w_tag_old)
        r_c_eop <= 1'b1;
    end
  end

  dct_coef_rom u_rom (
    .i_u    (r_u),
    .o_coef (w_coef)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_op[i]  = r_u[0] ? r_d[r_cbank][i] : r_s[r_cbank][i];
      w_mul[i] = PROD_W'(w_op[i]) * PROD_W'(w_coef[i]);
    end
  end

  always_comb begin
    w_sum = ACC_W'(r_prod[0]) + ACC_W'(r_prod[1])
          + ACC_W'(r_prod[2]) + ACC_W'(r_prod[3]);
    w_rnd = w_sum + L_RND;
    w_shr = w_rnd >>> COEF_FRAC;
    if (w_shr > L_MAX)
      w_sat = DCT_W'(L_MAX);
    else if (w_shr < L_MIN)
      w_sat = DCT_W'(L_MIN);
    else
      w_sat = DCT_W'(w_shr);
  end

  // Late eop with no X[7] left to compute rides a valid=0 beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        r_prod[i] <= '0;
      r_pvalid <= 1'b0;
      r_psop   <= 1'b0;
      r_peop   <= 1'b0;
      r_out    <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        r_prod[i] <= w_mul[i];
      r_pvalid <= r_busy;
      r_psop   <= r_busy && (r_u == 3'd0) && r_c_sop;
      r_peop   <= r_busy ? ((r_u == 3'd7) && (r_c_eop || w_tag_old))
                         : w_tag_old;
      r_out.data  <= r_pvalid ? w_sat : '0;
      r_out.valid <= r_pvalid;
      r_out.sop   <= r_psop;
      r_out.eop   <= r_peop;
    end
  end

  assign out.p = r_out;
  assign err   = r_err;

endmodule
